pipe_mem_arbiter: RTL and testbench
===================================

// Module: pipe_mem_arbiter
// PURPOSE
//  Sequences a single-ported RAM between the pipeline's instruction-fetch requester (I) and
//  data-memory requester (D). One access at a time; D has priority, with an anti-starvation
//  counter guaranteeing I progress. Per-requester hit pulses feed the hazard unit (dhit
//  flushes the execute latch; a missing ihit stalls fetch).
// PARAMETERS
//  MAX_D_STREAK  4     consecutive D grants allowed while I waits; then I is granted once
//  TIMEOUT       255   cycles in an access state without ram_ready before abort
//  CW            8     width of timeout counter; must hold TIMEOUT
// PORTS
//  CLK          in   1   clock, all state updates on rising edge
//  RST          in   1   synchronous, active-high reset
//  iREN         in   1   I read request, held until ihit
//  iaddr        in   32  I word address
//  dREN         in   1   D read request, held until dhit
//  dWEN         in   1   D write request, held until dhit
//  daddr        in   32  D word address
//  dstore       in   32  D write data
//  ram_ready    in   1   RAM completes current access this cycle
//  ram_load     in   32  RAM read data, valid with ram_ready
//  ram_ren      out  1   RAM read strobe
//  ram_wen      out  1   RAM write strobe
//  ram_addr     out  32  RAM address
//  ram_store    out  32  RAM write data
//  ihit         out  1   one-cycle pulse: I access done, iload valid
//  iload        out  32  instruction data
//  dhit         out  1   one-cycle pulse: D access done, dload valid on reads
//  dload        out  32  data read result
//  bus_err      out  1   sticky: an access timed out
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0, latched addr/data/op cleared, d_streak=0, tcnt=0, bus_err=0.
//   Reset mid-access abandons the access with no hit pulse.
//  FSM states IDLE, D_ACC, I_ACC (registered).
//   IDLE: D pending (dREN|dWEN) and !(iREN && d_streak==MAX_D_STREAK) -> D_ACC;
//    else iREN -> I_ACC; else stay. On the grant edge, latch addr, data and op
//    (dWEN has priority over dREN: a write).
//   D_ACC/I_ACC: ram_ren/ram_wen, ram_addr, ram_store driven from latched regs (registered,
//    glitch-free). ram_store=0 on reads. Leave on ram_ready or timeout.
//  Completion (combinational with ram_ready in access state): ihit/dhit=1 that cycle only if
//   the matching request is still asserted; a dropped request finishes silently.
//   iload/dload = ram_load during hit, hold last value otherwise. Next edge -> IDLE.
//  Latency: request seen in IDLE cycle N -> RAM strobes in N+1 -> earliest hit in N+1.
//   IDLE is mandatory between accesses: max one access per 2 cycles.
//  d_streak: +1 on each D grant while iREN=1 (saturates at MAX_D_STREAK); cleared on I grant,
//   or on D grant with iREN=0.
//  Timeout: tcnt cleared on grant, +1 per access cycle without ram_ready; at tcnt==TIMEOUT set
//   bus_err, deassert strobes, return IDLE, no hit. bus_err clears only on RST.
//  Simultaneous iREN+D pending in IDLE, streak below limit: D wins.
//  ram_ready outside access states: ignored.
// TESTING
//  T1 reset: RST=1 2 cycles mid D_ACC -> all outputs 0, no dhit, state IDLE next cycle.
//  T2 I read: iREN=1, iaddr=0x40, ram_ready 3 cycles after strobe, ram_load=0x8C220004
//   -> ram_ren=1 cycle after req, ram_addr=0x40, one ihit pulse, iload=0x8C220004.
//  T3 D write: dWEN=1, dREN=1, daddr=0x100, dstore=0xDEADBEEF
//   -> ram_wen=1, ram_ren=0, ram_store=0xDEADBEEF, single dhit.
//  T4 priority: iREN+dREN same cycle, ram_ready immediate -> D_ACC first, then I_ACC;
//   dhit before ihit, 2 cycles apart.
//  T5 starvation: iREN held, D requests back-to-back -> exactly 4 dhits, then ihit,
//   then D resumes.
//  T6 timeout: dREN=1, ram_ready never -> after 255 access cycles bus_err=1, strobes 0,
//   no dhit; following iREN serviced normally with bus_err still 1.

Source files
------------

// File: rtl/pipe_mem_arbiter.sv
// Single-ported RAM sequencer shared by instruction fetch (I) and data memory (D).
// D wins by default; a streak counter forces one I grant after MAX_D_STREAK D grants.
module pipe_mem_arbiter #(
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 255,
    parameter int CW           = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    input  logic        ram_ready,
    input  logic [31:0] ram_load,
    output logic        ram_ren,
    output logic        ram_wen,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_store,
    output logic        ihit,
    output logic [31:0] iload,
    output logic        dhit,
    output logic [31:0] dload,
    output logic        bus_err
);

    localparam int SW = $clog2(MAX_D_STREAK + 1);

    typedef enum logic [1:0] {IDLE, D_ACC, I_ACC} state_t;

    state_t         state_q, state_d;
    logic           ren_q, ren_d;
    logic           wen_q, wen_d;
    logic [31:0]    addr_q, addr_d;
    logic [31:0]    store_q, store_d;
    logic [SW-1:0]  streak_q, streak_d;
    logic [CW-1:0]  tcnt_q, tcnt_d;
    logic           bus_err_q, bus_err_d;
    logic [31:0]    iload_q, iload_d;
    logic [31:0]    dload_q, dload_d;
    logic           ihit_c, dhit_c;
    logic           d_pend;
    logic           i_starved;

    assign d_pend    = dREN | dWEN;
    assign i_starved = iREN && (streak_q == SW'(MAX_D_STREAK));

    always_comb begin
        state_d   = state_q;
        ren_d     = ren_q;
        wen_d     = wen_q;
        addr_d    = addr_q;
        store_d   = store_q;
        streak_d  = streak_q;
        tcnt_d    = tcnt_q;
        bus_err_d = bus_err_q;
        ihit_c    = 1'b0;
        dhit_c    = 1'b0;

        case (state_q)
            IDLE: begin
                if (d_pend && !i_starved) begin
                    state_d = D_ACC;
                    ren_d   = ~dWEN;
                    wen_d   = dWEN;
                    addr_d  = daddr;
                    store_d = dWEN ? dstore : 32'd0;
                    tcnt_d  = '0;
                    if (!iREN)
                        streak_d = '0;
                    else if (streak_q != SW'(MAX_D_STREAK))
                        streak_d = streak_q + SW'(1);
                end else if (iREN) begin
                    state_d  = I_ACC;
                    ren_d    = 1'b1;
                    wen_d    = 1'b0;
                    addr_d   = iaddr;
                    store_d  = 32'd0;
                    tcnt_d   = '0;
                    streak_d = '0;
                end
            end
            D_ACC, I_ACC: begin
                if (ram_ready) begin
                    // A requester that dropped its request mid-access gets no pulse.
                    if (state_q == D_ACC)
                        dhit_c = d_pend;
                    else
                        ihit_c = iREN;
                    state_d = IDLE;
                    ren_d   = 1'b0;
                    wen_d   = 1'b0;
                end else if (tcnt_q == CW'(TIMEOUT - 1)) begin
                    state_d   = IDLE;
                    ren_d     = 1'b0;
                    wen_d     = 1'b0;
                    tcnt_d    = CW'(TIMEOUT);
                    bus_err_d = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ihit    = ihit_c & ~RST;
    assign dhit    = dhit_c & ~RST;
    assign iload_d = ihit ? ram_load : iload_q;
    assign dload_d = dhit ? ram_load : dload_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            ren_q     <= 1'b0;
            wen_q     <= 1'b0;
            addr_q    <= 32'd0;
            store_q   <= 32'd0;
            streak_q  <= '0;
            tcnt_q    <= '0;
            bus_err_q <= 1'b0;
            iload_q   <= 32'd0;
            dload_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            ren_q     <= ren_d;
            wen_q     <= wen_d;
            addr_q    <= addr_d;
            store_q   <= store_d;
            streak_q  <= streak_d;
            tcnt_q    <= tcnt_d;
            bus_err_q <= bus_err_d;
            iload_q   <= iload_d;
            dload_q   <= dload_d;
        end
    end

    assign ram_ren   = ren_q;
    assign ram_wen   = wen_q;
    assign ram_addr  = addr_q;
    assign ram_store = store_q;
    assign iload     = iload_d;
    assign dload     = dload_d;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Directed bench for pipe_mem_arbiter: a RAM responder with programmable latency and
// per-requester scoreboards checked whenever a hit pulse appears.
module tb_pipe_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RST, iREN, dREN, dWEN, ram_ready;
    logic [31:0] iaddr, daddr, dstore, ram_load;
    logic        ram_ren, ram_wen, ihit, dhit, bus_err;
    logic [31:0] ram_addr, ram_store, iload, dload;

    pipe_mem_arbiter dut (
        .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .ram_ready(ram_ready), .ram_load(ram_load),
        .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_store(ram_store),
        .ihit(ihit), .iload(iload), .dhit(dhit), .dload(dload), .bus_err(bus_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
    } exp_t;

    exp_t iq[$];
    exp_t dq[$];
    int   passed = 0;
    int   total  = 0;
    int   lat    = -1;
    int   acc_cnt = 0;
    int   ni = 0;
    int   nd = 0;
    bit   got_i, got_d;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'h40)
            return 32'h8C220004;
        return (a ^ 32'h5A5A0000) + 32'd7;
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    endtask

    function automatic exp_t mk(input logic [31:0] a, input logic w, input logic [31:0] d);
        exp_t e;
        e.addr = a;
        e.wr   = w;
        e.data = d;
        return e;
    endfunction

    // One clock: drive the RAM response, sample at negedge, return at posedge+1.
    task automatic tick();
        exp_t e;
        if (ram_ren === 1'b1 || ram_wen === 1'b1) begin
            ram_ready = (lat >= 0) && (acc_cnt == lat);
            ram_load  = ram_ready ? mem_val(ram_addr) : 32'hBAD0BAD0;
            acc_cnt++;
        end else begin
            ram_ready = 1'b0;
            ram_load  = 32'hBAD0BAD0;
            acc_cnt   = 0;
        end
        @(negedge CLK);
        got_i = (ihit === 1'b1);
        got_d = (dhit === 1'b1);
        if (got_i) begin
            ni++;
            chk("ihit_expected", 32'(iq.size() > 0), 32'd1);
            if (iq.size() > 0) begin
                e = iq.pop_front();
                chk("i_addr", ram_addr, e.addr);
                chk("iload", iload, mem_val(e.addr));
            end
        end
        if (got_d) begin
            nd++;
            chk("dhit_expected", 32'(dq.size() > 0), 32'd1);
            if (dq.size() > 0) begin
                e = dq.pop_front();
                chk("d_addr", ram_addr, e.addr);
                chk("d_wen", 32'(ram_wen), 32'(e.wr));
                chk("d_ren", 32'(ram_ren), 32'(!e.wr));
                chk("d_store", ram_store, e.wr ? e.data : 32'd0);
                if (!e.wr)
                    chk("dload", dload, mem_val(e.addr));
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_hit(output byte k, output int n);
        k = "-";
        n = 0;
        while (k == "-" && n < 600) begin
            tick();
            n++;
            if (got_d)
                k = "D";
            else if (got_i)
                k = "I";
        end
        if (k == "-")
            chk("hit_timeout", 32'(n), 32'd0);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ren"}, 32'(ram_ren), 32'd0);
        chk({tag, "_wen"}, 32'(ram_wen), 32'd0);
        chk({tag, "_addr"}, ram_addr, 32'd0);
        chk({tag, "_store"}, ram_store, 32'd0);
        chk({tag, "_ihit"}, 32'(ihit), 32'd0);
        chk({tag, "_dhit"}, 32'(dhit), 32'd0);
        chk({tag, "_iload"}, iload, 32'd0);
        chk({tag, "_dload"}, dload, 32'd0);
        chk({tag, "_buserr"}, 32'(bus_err), 32'd0);
    endtask

    initial begin
        byte k, k2;
        int  n, n2, ni0, nd0, sc, dcount;
        byte seq[$];
        string exp_seq;

        RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0;
        iaddr = 0; daddr = 0; dstore = 0; ram_ready = 0; ram_load = 0;
        tick();
        tick();
        RST = 1'b0;
        chk_idle_outputs("por");

        // T1: reset in the middle of a D access.
        dREN = 1; daddr = 32'h300; lat = -1;
        tick();
        tick();
        chk("t1_ren_active", 32'(ram_ren), 32'd1);
        RST = 1'b1;
        tick();
        tick();
        dREN = 0;
        RST = 1'b0;
        chk_idle_outputs("t1");
        tick();
        chk("t1_idle_ren", 32'(ram_ren), 32'd0);
        $display("T1 reset mid-access: ram_ren=%0b dhits=%0d", ram_ren, nd);

        // T2: instruction read, ready three cycles after the strobe.
        ni0 = ni;
        iREN = 1; iaddr = 32'h40; lat = 3;
        iq.push_back(mk(32'h40, 1'b0, 32'd0));
        chk("t2_no_strobe_yet", 32'(ram_ren), 32'd0);
        tick();
        chk("t2_ren", 32'(ram_ren), 32'd1);
        chk("t2_addr", ram_addr, 32'h40);
        wait_hit(k, n);
        iREN = 0;
        chk("t2_kind", 32'(k), 32'("I"));
        chk("t2_latency", 32'(n), 32'd4);
        tick(); tick(); tick();
        chk("t2_ihit_count", 32'(ni - ni0), 32'd1);
        chk("t2_iload_hold", iload, 32'h8C220004);
        $display("T2 I read: addr=40 iload=%h ticks=%0d", iload, n);

        // T3: data write wins over simultaneous read strobe.
        nd0 = nd;
        dWEN = 1; dREN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF; lat = 1;
        dq.push_back(mk(32'h100, 1'b1, 32'hDEADBEEF));
        wait_hit(k, n);
        dWEN = 0; dREN = 0;
        chk("t3_kind", 32'(k), 32'("D"));
        chk("t3_latency", 32'(n), 32'd3);
        tick(); tick(); tick();
        chk("t3_dhit_count", 32'(nd - nd0), 32'd1);
        $display("T3 D write: addr=100 data=deadbeef ticks=%0d", n);

        // T4: simultaneous I and D requests, immediate ready.
        lat = 0;
        iREN = 1; iaddr = 32'h60;
        dREN = 1; daddr = 32'h180;
        iq.push_back(mk(32'h60, 1'b0, 32'd0));
        dq.push_back(mk(32'h180, 1'b0, 32'd0));
        wait_hit(k, n);
        dREN = 0;
        wait_hit(k2, n2);
        iREN = 0;
        chk("t4_first", 32'(k), 32'("D"));
        chk("t4_second", 32'(k2), 32'("I"));
        chk("t4_first_lat", 32'(n), 32'd2);
        chk("t4_gap", 32'(n2), 32'd2);
        tick();
        $display("T4 priority: first=%c second=%c gap=%0d", k, k2, n2);

        // T5: anti-starvation after four consecutive D grants.
        iREN = 1; iaddr = 32'h80;
        dREN = 1; daddr = 32'h200;
        iq.push_back(mk(32'h80, 1'b0, 32'd0));
        dq.push_back(mk(32'h200, 1'b0, 32'd0));
        dcount = 0;
        for (int h = 0; h < 6; h++) begin
            wait_hit(k, n);
            seq.push_back(k);
            if (k == "D") begin
                dcount++;
                if (dcount < 5) begin
                    daddr = daddr + 32'd4;
                    dq.push_back(mk(daddr, 1'b0, 32'd0));
                end else begin
                    dREN = 0;
                end
            end else if (k == "I") begin
                iREN = 0;
            end
        end
        iREN = 0; dREN = 0;
        exp_seq = "DDDDID";
        chk("t5_len", 32'(seq.size()), 32'd6);
        for (int h = 0; h < 6 && h < seq.size(); h++)
            chk($sformatf("t5_seq%0d", h), 32'(seq[h]), 32'(exp_seq[h]));
        tick();
        chk("t5_buserr", 32'(bus_err), 32'd0);
        $display("T5 starvation: hit order=%s", string'({seq[0], seq[1], seq[2], seq[3], seq[4], seq[5]}));

        // T6: timeout with RAM never ready, then a normal I access.
        nd0 = nd;
        dREN = 1; daddr = 32'h500; lat = -1;
        sc = 0;
        for (int g = 0; g < 600; g++) begin
            tick();
            if (ram_ren === 1'b1)
                sc++;
            else if (sc > 0)
                break;
        end
        dREN = 0;
        chk("t6_access_cycles", 32'(sc), 32'd255);
        chk("t6_buserr", 32'(bus_err), 32'd1);
        chk("t6_ren_off", 32'(ram_ren), 32'd0);
        chk("t6_wen_off", 32'(ram_wen), 32'd0);
        tick();
        chk("t6_no_regrant", 32'(ram_ren), 32'd0);
        chk("t6_no_dhit", 32'(nd - nd0), 32'd0);
        iREN = 1; iaddr = 32'h44; lat = 0;
        iq.push_back(mk(32'h44, 1'b0, 32'd0));
        wait_hit(k, n);
        iREN = 0;
        chk("t6_i_kind", 32'(k), 32'("I"));
        tick();
        chk("t6_buserr_sticky", 32'(bus_err), 32'd1);
        $display("T6 timeout: access_cycles=%0d bus_err=%0b", sc, bus_err);

        chk("iq_drained", 32'(iq.size()), 32'd0);
        chk("dq_drained", 32'(dq.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
